// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin using one full-subtractor cell, LSB first.
// Results are published only on the RUN->DONE edge, so no partial results are ever visible.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbit, bbit, last;

    assign dbit   = a_q[0] ^ b_q[0] ^ br_q;
    assign bbit   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign diff_o = diff_q;
    assign bout_o = bout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                a_d     = a_i;
                b_d     = b_i;
                br_d    = bin_i;
                cnt_d   = '0;
            end
            RUN: begin
                // diff bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bbit;
                w_d   = {dbit, w_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    diff_d  = {dbit, w_q[WIDTH-1:1]};
                    bout_d  = bbit;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed and random checks of the serial subtractor controller.
module tb_serial_sub_ctrl;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, bin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, bout;
    logic [7:0] diff;
    int         checks = 0, errors = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start_i(start), .a_i(a), .b_i(b), .bin_i(bin),
        .busy_o(busy), .done_o(done), .diff_o(diff), .bout_o(bout)
    );

    always #5 clk = ~clk;

    // Issues one request and observes until the block returns to IDLE (bounded).
    // lat = number of edges after the accepting edge at which done appears.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          output logic [7:0] d, output logic bo,
                          output int lat, output int bcnt, output int nd);
        logic got;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; bin = tbin;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; bcnt = 0; nd = 0; got = 1'b0; d = 'x; bo = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                nd++;
                if (!got) begin
                    got = 1'b1; lat = k - 1; d = diff; bo = bout;
                end
            end
            if (!busy && got) break;
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bout, diff} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b bout=%b diff=%h, want all 0", busy, done, bout, diff);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        logic [7:0] d; logic bo; int lat, bc, nd;
        run_op(8'd200, 8'd55, 1'b0, d, bo, lat, bc, nd);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++;
        if (d !== 8'd145 || bo !== 1'b0) begin errors++; $display("FAIL basic_result: got %0d/%b want 145/0", d, bo); end
        checks++;
        if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", bc); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    endtask

    task automatic test_vectors;
        logic [7:0] va[3] = '{8'd5, 8'd0, 8'hAA};
        logic [7:0] vb[3] = '{8'd9, 8'd0, 8'hAA};
        logic       vi[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] vd[3] = '{8'hFC, 8'hFF, 8'h00};
        logic       vo[3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] d; logic bo; int lat, bc, nd;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vi[i], d, bo, lat, bc, nd);
            checks++;
            if (d !== vd[i] || bo !== vo[i]) begin
                errors++;
                $display("FAIL vector%0d: got %h/%b want %h/%b", i, d, bo, vd[i], vo[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [7:0] d = 'x; int nd = 0, extra = 0;
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd1; bin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin nd++; d = diff; end
            if (k == 3) begin start = 1'b1; a = 8'd7; b = 8'd7; end
            if (k == 4) start = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (nd !== 1 || d !== 8'd99) begin errors++; $display("FAIL ignore_result: done=%0d diff=%0d want 1/99", nd, d); end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignore_no_queue: busy/done cycles=%0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        int t[$]; logic held_ok = 1'b1; int bad = 0;
        @(negedge clk);
        start = 1'b1; a = 8'd20; b = 8'd3; bin = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (done) begin
                t.push_back(k);
                if (diff !== 8'd17) bad++;
            end
            if (k == 4 && diff !== 8'd99) held_ok = 1'b0;
        end
        start = 1'b0;
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        checks++;
        if (!held_ok) begin errors++; $display("FAIL b2b_diff_hold: diff changed mid-run, want 99 held"); end
        checks++;
        if (t.size() < 3) begin
            errors++; $display("FAIL b2b_done_count: got %0d want >=3", t.size());
        end else begin
            checks++;
            if (t[1] - t[0] !== 10 || t[2] - t[1] !== 10) begin
                errors++; $display("FAIL b2b_period: got %0d,%0d want 10,10", t[1] - t[0], t[2] - t[1]);
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_result: %0d wrong diffs want 17", bad); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_abort;
        logic [7:0] d; logic bo; int lat, bc, nd, nd2 = 0;
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F; bin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: busy=%b done=%b diff=%h bout=%b want 0", busy, done, diff, bout);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) nd2++;
        end
        checks++;
        if (nd2 !== 0) begin errors++; $display("FAIL abort_no_done: active cycles=%0d want 0", nd2); end
        run_op(8'd9, 8'd3, 1'b0, d, bo, lat, bc, nd);
        checks++;
        if (d !== 8'd6 || bo !== 1'b0 || lat !== 8) begin
            errors++; $display("FAIL abort_recover: got %0d/%b lat %0d want 6/0 lat 8", d, bo, lat);
        end
    endtask

    task automatic test_random;
        logic [7:0] ta, tb, d; logic ti, bo; logic [8:0] exp; int lat, bc, nd;
        for (int n = 0; n < 1000; n++) begin
            ta = 8'($urandom_range(0, 255));
            tb = 8'($urandom_range(0, 255));
            ti = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(ta, tb, ti, d, bo, lat, bc, nd);
            exp = {1'b0, ta} - {1'b0, tb} - {8'd0, ti};
            checks++;
            if ({bo, d} !== exp || nd !== 1) begin
                errors++;
                $display("FAIL random%0d: %h-%h-%b got %b/%h done=%0d want %b/%h done=1",
                         n, ta, tb, ti, bo, d, nd, exp[8], exp[7:0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_ignore_start;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
